// File: rtl/order_match_engine.sv
// order_match_engine
// Single-symbol limit-order matcher. Tracks the best bid and best ask from
// pulsed order strobes and detects a crossed book. A crossed book runs a
// one-cycle MATCH that executes the trade at the ask price. The trade is
// skipped and the engine halts when the price jumps too far from the previous
// trade. A stretched match_flag marks each executed trade.
module order_match_engine #(
  parameter int unsigned MATCH_HOLD  = 25_000_000,
  parameter logic [7:0]  BREAK_DELTA = 8'd32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       buy_valid,
  input  logic [7:0] buy_in,
  input  logic       sell_valid,
  input  logic [7:0] sell_in,
  input  logic       halt_req,
  input  logic       resume,
  output logic       order_ready,
  output logic [7:0] buy_price,
  output logic [7:0] sell_price,
  output logic [7:0] spread_now,
  output logic [7:0] trade_count,
  output logic [1:0] state,
  output logic       halt_flag,
  output logic       match_flag,
  output logic [7:0] last_trade
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    QUOTE = 2'b01,
    MATCH = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam int HOLD_W = $clog2(MATCH_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MATCH_HOLD);

  state_t            state_q;
  state_t            state_d;
  logic              bid_v;
  logic              ask_v;
  logic              lt_v;
  logic [HOLD_W-1:0] hold_q;

  logic              crossed;
  logic              buy_acc;
  logic              sell_acc;
  logic              book_clear;
  logic              trade_commit;
  logic [8:0]        diff;
  logic [8:0]        abs_diff;
  logic              breaker_trip;

  // Book status and the acceptance rules for incoming strobes.
  assign crossed     = bid_v & ask_v & (buy_price >= sell_price);
  assign order_ready = ((state_q == IDLE) | (state_q == QUOTE)) & ~crossed & ~halt_req;
  assign buy_acc     = order_ready & buy_valid  & (~bid_v | (buy_in  > buy_price));
  assign sell_acc    = order_ready & sell_valid & (~ask_v | (sell_in < sell_price));
  assign spread_now  = (bid_v & ask_v & ~crossed) ? (sell_price - buy_price) : 8'h00;

  // Circuit breaker: the absolute jump from the previous trade, in 9-bit math
  // so that the signed difference cannot wrap.
  assign diff         = {1'b0, sell_price} - {1'b0, last_trade};
  assign abs_diff     = diff[8] ? (9'd0 - diff) : diff;
  assign breaker_trip = lt_v & (abs_diff > {1'b0, BREAK_DELTA});

  assign state      = state_q;
  assign halt_flag  = (state_q == HALT);
  assign match_flag = (hold_q != '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; halt_req overrides everything outside HALT.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    book_clear   = 1'b0;
    trade_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt_req) begin
          state_d    = HALT;
          book_clear = 1'b1;
        end else if (buy_acc | sell_acc) begin
          state_d = QUOTE;
        end
      end
      QUOTE: begin
        if (halt_req) begin
          state_d    = HALT;
          book_clear = 1'b1;
        end else if (crossed) begin
          state_d = MATCH;
        end else if (!(bid_v | ask_v | buy_acc | sell_acc)) begin
          state_d = IDLE;
        end
      end
      MATCH: begin
        book_clear = 1'b1;
        if (halt_req || breaker_trip) begin
          state_d = HALT;
        end else begin
          state_d      = IDLE;
          trade_commit = 1'b1;
        end
      end
      HALT: begin
        if (resume && !halt_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Best bid/ask registers: cleared on trade or halt, improved by accepted orders.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buy_price  <= 8'h00;
      sell_price <= 8'hFF;
      bid_v      <= 1'b0;
      ask_v      <= 1'b0;
    end else if (book_clear) begin
      buy_price  <= 8'h00;
      sell_price <= 8'hFF;
      bid_v      <= 1'b0;
      ask_v      <= 1'b0;
    end else begin
      if (buy_acc) begin
        buy_price <= buy_in;
        bid_v     <= 1'b1;
      end
      if (sell_acc) begin
        sell_price <= sell_in;
        ask_v      <= 1'b1;
      end
    end
  end

  // Trade record: the count wraps modulo 256 and last_trade holds the ask price.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trade_count <= 8'h00;
      last_trade  <= 8'h00;
      lt_v        <= 1'b0;
    end else if (trade_commit) begin
      trade_count <= trade_count + 8'h01;
      last_trade  <= sell_price;
      lt_v        <= 1'b1;
    end
  end

  // match_flag stretcher: each trade reloads it and it counts down to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               hold_q <= '0;
    else if (trade_commit)     hold_q <= HOLD_LOAD;
    else if (hold_q != '0)     hold_q <= hold_q - HOLD_W'(1);
  end

endmodule

// File: tb/tb_order_match_engine.sv
// Directed testbench for order_match_engine, with MATCH_HOLD set to 4.
module tb_order_match_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       buy_valid;
  logic [7:0] buy_in;
  logic       sell_valid;
  logic [7:0] sell_in;
  logic       halt_req;
  logic       resume;
  logic       order_ready;
  logic [7:0] buy_price;
  logic [7:0] sell_price;
  logic [7:0] spread_now;
  logic [7:0] trade_count;
  logic [1:0] state;
  logic       halt_flag;
  logic       match_flag;
  logic [7:0] last_trade;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  order_match_engine #(
    .MATCH_HOLD (4),
    .BREAK_DELTA(8'd32)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .buy_valid  (buy_valid),
    .buy_in     (buy_in),
    .sell_valid (sell_valid),
    .sell_in    (sell_in),
    .halt_req   (halt_req),
    .resume     (resume),
    .order_ready(order_ready),
    .buy_price  (buy_price),
    .sell_price (sell_price),
    .spread_now (spread_now),
    .trade_count(trade_count),
    .state      (state),
    .halt_flag  (halt_flag),
    .match_flag (match_flag),
    .last_trade (last_trade)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic order(input logic bv, input logic [7:0] b, input logic sv, input logic [7:0] s);
    buy_valid  = bv;
    buy_in     = b;
    sell_valid = sv;
    sell_in    = s;
    tick();
    buy_valid  = 1'b0;
    sell_valid = 1'b0;
  endtask

  // Simultaneous buy/sell at price p: accept, QUOTE crossed, MATCH exit.
  task automatic trade(input logic [7:0] p);
    order(1'b1, p, 1'b1, p);
    tick();
    tick();
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int mcount;
    resetn     = 1'b1;
    buy_valid  = 1'b0;
    buy_in     = 8'h00;
    sell_valid = 1'b0;
    sell_in    = 8'h00;
    halt_req   = 1'b0;
    resume     = 1'b0;

    // Reset is asynchronous: values must appear before any clock edge.
    #3 resetn = 1'b0;
    #1;
    check("rst_buy",   buy_price,   16'h00);
    check("rst_sell",  sell_price,  16'hFF);
    check("rst_spread",spread_now,  16'h00);
    check("rst_count", trade_count, 16'h00);
    check("rst_state", state,       16'h0);
    check("rst_halt",  halt_flag,   16'h0);
    check("rst_match", match_flag,  16'h0);
    check("rst_last",  last_trade,  16'h00);
    tick();
    resetn = 1'b1;
    #1;
    check("rst_ready", order_ready, 16'h1);

    // Quote building and dropped non-improving orders.
    order(1'b1, 8'h40, 1'b1, 8'h50);
    check("q_state",  state,      16'h1);
    check("q_buy",    buy_price,  16'h40);
    check("q_sell",   sell_price, 16'h50);
    check("q_spread", spread_now, 16'h10);
    order(1'b1, 8'h45, 1'b0, 8'h00);
    check("q_bid45",  buy_price,  16'h45);
    check("q_spr0b",  spread_now, 16'h0B);
    order(1'b1, 8'h30, 1'b0, 8'h00);
    check("q_bid_drop", buy_price, 16'h45);
    order(1'b0, 8'h00, 1'b1, 8'h60);
    check("q_ask_drop", sell_price, 16'h50);

    // Crossing sell executes a trade at the ask price.
    order(1'b0, 8'h00, 1'b1, 8'h42);
    check("x_state", state,       16'h1);
    check("x_ready", order_ready, 16'h0);
    check("x_spread",spread_now,  16'h00);
    buy_valid = 1'b1;
    buy_in    = 8'h99;
    tick();
    check("m_state", state,     16'h2);
    check("m_drop",  buy_price, 16'h45);
    tick();
    buy_valid = 1'b0;
    check("t_state", state,       16'h0);
    check("t_count", trade_count, 16'h01);
    check("t_last",  last_trade,  16'h42);
    check("t_buy",   buy_price,   16'h00);
    check("t_sell",  sell_price,  16'hFF);
    mcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (match_flag) mcount++;
      tick();
    end
    check("match_len", mcount[15:0], 16'd4);

    // Breaker: 0x90 vs 0x42 exceeds the allowed jump.
    order(1'b1, 8'h95, 1'b0, 8'h00);
    order(1'b0, 8'h00, 1'b1, 8'h90);
    tick();
    tick();
    check("brk_state", state,       16'h3);
    check("brk_halt",  halt_flag,   16'h1);
    check("brk_count", trade_count, 16'h01);
    check("brk_last",  last_trade,  16'h42);
    check("brk_ready", order_ready, 16'h0);
    order(1'b1, 8'h10, 1'b1, 8'h20);
    check("h_ign_buy",  buy_price,  16'h00);
    check("h_ign_sell", sell_price, 16'hFF);
    halt_req = 1'b1;
    resume   = 1'b1;
    tick();
    check("h_both", state, 16'h3);
    halt_req = 1'b0;
    tick();
    resume = 1'b0;
    check("h_resume", state,     16'h0);
    check("h_flag0",  halt_flag, 16'h0);

    // Manual halt from QUOTE clears the book.
    order(1'b1, 8'h30, 1'b0, 8'h00);
    check("mh_quote", state, 16'h1);
    halt_req = 1'b1;
    #1;
    check("mh_ready", order_ready, 16'h0);
    tick();
    halt_req = 1'b0;
    check("mh_state", state,     16'h3);
    check("mh_buy",   buy_price, 16'h00);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("mh_idle", state, 16'h0);

    // Reset asserted while in MATCH.
    order(1'b1, 8'h30, 1'b1, 8'h28);
    tick();
    check("rm_state", state, 16'h2);
    resetn = 1'b0;
    #1;
    check("rm_state0", state,       16'h0);
    check("rm_count",  trade_count, 16'h00);
    check("rm_last",   last_trade,  16'h00);
    check("rm_buy",    buy_price,   16'h00);
    check("rm_sell",   sell_price,  16'hFF);
    tick();
    resetn = 1'b1;
    #1;

    // First trade never trips; then a jump of exactly the delta passes and delta+1 trips.
    trade(8'hC0);
    check("f_state", state,       16'h0);
    check("f_count", trade_count, 16'h01);
    check("f_last",  last_trade,  16'hC0);
    trade(8'hA0);
    check("d32_state", state,       16'h0);
    check("d32_count", trade_count, 16'h02);
    check("d32_last",  last_trade,  16'hA0);
    trade(8'h7F);
    check("d33_state", state,       16'h3);
    check("d33_count", trade_count, 16'h02);
    check("d33_last",  last_trade,  16'hA0);
    resume = 1'b1;
    tick();
    resume = 1'b0;

    // trade_count wrap: 253 more trades reach FF, one more wraps to 00.
    for (int i = 0; i < 253; i++) trade(8'hA0);
    check("wrap_ff", trade_count, 16'hFF);
    trade(8'hA0);
    check("wrap_00",    trade_count, 16'h00);
    check("wrap_state", state,       16'h0);

    // Simultaneous equal buy/sell after reset trades at that price.
    do_reset();
    order(1'b1, 8'h20, 1'b1, 8'h20);
    check("eq_state",  state,       16'h1);
    check("eq_ready",  order_ready, 16'h0);
    check("eq_spread", spread_now,  16'h00);
    tick();
    tick();
    check("eq_idle",  state,       16'h0);
    check("eq_last",  last_trade,  16'h20);
    check("eq_count", trade_count, 16'h01);
    check("eq_match", match_flag,  16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
